sb_tx_serializer: RTL and testbench

Sideband transmitter for the logical PHY: accepts 64-bit sideband words from the link layer into a small FIFO and serializes each one onto a forwarded clock/data pin pair. It is the partner of the sideband receiver, which samples data on the falling edge of the forwarded clock. Each transfer is 64 data UIs followed by a 32-UI gap. Runs entirely in the 800 MHz system domain.

---
 rtl/sb_tx_serializer.sv | 166 ++++++++++++++++
 tb/tb_sb_tx_serializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_serializer.sv
// ============================================================================
// Module   : sb_tx_serializer
// Purpose  : Sideband transmitter - FIFO of 64-bit words serialized onto a
//            forwarded clock/data pin pair (64 data UIs + 32-UI gap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_tx_serializer #(
  parameter int buffer_size = 4
) (
  input  logic        clk_800MHz,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [63:0] data_i,
  input  logic        valid_i,
  output logic        clkPin_o,
  output logic        dataPin_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        busy_o,
  output logic        msg_sent_o
);

  localparam int ADDR_W = $clog2(buffer_size);
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [63:0]       mem [buffer_size];
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [CNT_W-1:0]  count;
  logic              wr_en;
  logic              pop;
  logic [63:0]       head;

  state_t      state, state_n;
  logic        clk_pin, clk_n;
  logic        data_pin, data_n;
  logic [5:0]  ui_cnt, ui_n;
  logic        phase, phase_n;
  logic [63:0] shift_reg, shift_n;
  logic        msg_sent, msg_n;
  logic        start;
  logic        load;

  assign full_o     = (count == CNT_W'(buffer_size));
  assign empty_o    = (count == '0);
  assign wr_en      = valid_i & ~full_o;
  assign head       = mem[rd_idx];
  assign start      = enable_i & ~empty_o;
  assign clkPin_o   = clk_pin;
  assign dataPin_o  = data_pin;
  assign busy_o     = (state != IDLE);
  assign msg_sent_o = msg_sent;

  always_ff @(posedge clk_800MHz) begin
    if (wr_en) mem[wr_idx] <= data_i;
  end

  // pop only ever sees registered count, so a same-cycle write cannot bypass
  always_ff @(posedge clk_800MHz) begin
    if (!reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_idx <= wr_idx + ADDR_W'(1);
      if (pop)   rd_idx <= rd_idx + ADDR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_800MHz) begin
    if (!reset) begin
      state     <= IDLE;
      clk_pin   <= 1'b0;
      data_pin  <= 1'b0;
      ui_cnt    <= '0;
      phase     <= 1'b0;
      shift_reg <= '0;
      msg_sent  <= 1'b0;
    end else begin
      state     <= state_n;
      clk_pin   <= clk_n;
      data_pin  <= data_n;
      ui_cnt    <= ui_n;
      phase     <= phase_n;
      shift_reg <= shift_n;
      msg_sent  <= msg_n;
    end
  end

  always_comb begin
    state_n = state;
    clk_n   = clk_pin;
    data_n  = data_pin;
    ui_n    = ui_cnt;
    phase_n = phase;
    shift_n = shift_reg;
    msg_n   = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        clk_n  = 1'b0;
        data_n = 1'b0;
        load   = start;
      end
      SEND: begin
        if (phase) begin
          clk_n   = 1'b0;
          phase_n = 1'b0;
          if (ui_cnt == 6'd63) begin
            state_n = GAP;
            ui_n    = '0;
          end
        end else begin
          clk_n   = 1'b1;
          phase_n = 1'b1;
          ui_n    = ui_cnt + 6'd1;
          data_n  = shift_reg[62];
          shift_n = {shift_reg[62:0], 1'b0};
        end
      end
      GAP: begin
        if (phase) begin
          clk_n   = 1'b0;
          phase_n = 1'b0;
          ui_n    = ui_cnt + 6'd1;
          msg_n   = (ui_cnt == 6'd31);
        end else if (ui_cnt == 6'd32) begin
          // gap finished: the low half of UI 31 doubles as the restart slot
          load = start;
          if (!start) state_n = IDLE;
        end else begin
          clk_n   = 1'b1;
          phase_n = 1'b1;
          data_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_n = head;
      clk_n   = 1'b1;
      data_n  = head[63];
      ui_n    = '0;
      phase_n = 1'b1;
      state_n = SEND;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sb_tx_serializer.sv
// ============================================================================
// Module   : tb_sb_tx_serializer
// Purpose  : Scoreboard bench for sb_tx_serializer (serial word capture).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sb_tx_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i;
  logic [63:0] data_i;
  logic        valid_i;
  logic        clkPin_o, dataPin_o, full_o, empty_o, busy_o, msg_sent_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] sb[$];

  sb_tx_serializer #(.buffer_size(4)) dut (
    .clk_800MHz(clk), .reset(reset), .enable_i(enable_i), .data_i(data_i),
    .valid_i(valid_i), .clkPin_o(clkPin_o), .dataPin_o(dataPin_o),
    .full_o(full_o), .empty_o(empty_o), .busy_o(busy_o), .msg_sent_o(msg_sent_o)
  );

  always #1 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: rebuild words from forwarded-clock falling edges, audit the gap.
  logic [63:0] word;
  int          nbits = 0, ngap = 0;
  bit          in_gap = 0, gapbad = 0, prev_clk = 0;
  always @(negedge clk) begin
    if (!reset) begin
      nbits = 0; ngap = 0; in_gap = 0; gapbad = 0; prev_clk = 0;
    end else begin
      if (prev_clk && !clkPin_o) begin
        if (!in_gap) begin
          word = {word[62:0], dataPin_o};
          nbits++;
          if (nbits == 64) begin
            if (sb.size() == 0) check("unexpected_word", word, 64'hx);
            else check("word", word, sb.pop_front());
            nbits = 0; in_gap = 1; ngap = 0; gapbad = 0;
          end
        end else begin
          ngap++;
          if (dataPin_o) gapbad = 1;
        end
      end
      if (in_gap && clkPin_o && dataPin_o) gapbad = 1;
      if (msg_sent_o) begin
        check("gap_pulses", 64'(ngap), 64'd32);
        check("gap_data_zero", {63'd0, gapbad}, 64'd0);
        in_gap = 0;
      end
      prev_clk = clkPin_o;
    end
  end

  task automatic write_word(input logic [63:0] w);
    @(negedge clk);
    data_i = w; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic write_when_room(input logic [63:0] w);
    int n = 0;
    while (full_o && n < 1000) begin @(negedge clk); n++; end
    if (full_o) check("room_timeout", 64'd1, 64'd0);
    sb.push_back(w);
    write_word(w);
  endtask

  task automatic wait_msg(output int at, output bit ok);
    ok = 0; at = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (msg_sent_o) begin ok = 1; at = cyc; return; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!(empty_o && !busy_o) && n < 3000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check("drain_done", {62'd0, busy_o, empty_o}, 64'd1);
  endtask

  initial begin
    int t[4];
    int at, n;
    bit ok;
    reset = 1'b0; enable_i = 1'b0; data_i = '0; valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk",  {63'd0, clkPin_o},   64'd0);
    check("rst_data", {63'd0, dataPin_o},  64'd0);
    check("rst_full", {63'd0, full_o},     64'd0);
    check("rst_empty",{63'd0, empty_o},    64'd1);
    check("rst_busy", {63'd0, busy_o},     64'd0);
    check("rst_msg",  {63'd0, msg_sent_o}, 64'd0);
    reset = 1'b1;

    // single word: latency and full message length
    enable_i = 1'b1;
    sb.push_back(64'hA5A5_0000_FFFF_1234);
    write_word(64'hA5A5_0000_FFFF_1234);
    check("e0_empty", {63'd0, empty_o}, 64'd0);
    @(negedge clk);
    check("e1_clk_busy_bit63", {61'd0, clkPin_o, busy_o, dataPin_o}, 64'h7);
    n = 1;
    while (!msg_sent_o && n < 300) begin @(negedge clk); n++; end
    check("msg_sent_cycle", 64'(n), 64'd192);
    @(negedge clk);
    check("after_msg_idle", {62'd0, busy_o, clkPin_o}, 64'd0);

    // fill with enable low, overflow dropped, back-to-back period
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(64'h1000_0000_0000_0000 * (i + 1) + 64'h0F0F);
      write_word(64'h1000_0000_0000_0000 * (i + 1) + 64'h0F0F);
      if (i == 3) check("full_after_4", {63'd0, full_o}, 64'd1);
    end
    check("full_after_5", {63'd0, full_o}, 64'd1);
    check("not_started", {63'd0, busy_o}, 64'd0);
    enable_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_msg(at, ok);
      check("b2b_msg_seen", {63'd0, ok}, 64'd1);
      t[i] = at;
    end
    for (int i = 1; i < 4; i++) check("b2b_period", 64'(t[i] - t[i-1]), 64'd192);
    drain();
    check("b2b_clk_low", {63'd0, clkPin_o}, 64'd0);

    // write while full in the pop cycle is dropped; at count 3 it is kept
    enable_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(64'hC0DE_0000_0000_0000 + 64'(i));
      write_word(64'hC0DE_0000_0000_0000 + 64'(i));
    end
    @(negedge clk);
    enable_i = 1'b1; valid_i = 1'b1; data_i = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    valid_i = 1'b0;
    check("full_pop_write_dropped", {62'd0, full_o, busy_o}, 64'd1);
    wait_msg(at, ok);
    check("c3_msg_seen", {63'd0, ok}, 64'd1);
    sb.push_back(64'hBEEF_0000_1111_2222);
    data_i = 64'hBEEF_0000_1111_2222; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check("c3_count_kept", {62'd0, full_o, empty_o}, 64'd0);
    drain();

    // nine words with interleaved writes: index wrap-around, ordering
    for (int i = 0; i < 9; i++) begin
      write_when_room(64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h1111_0000_0001_0101));
      repeat ((i % 3) * 70) @(negedge clk);
    end
    drain();

    // reset during UI 20 of SEND, with a second word queued
    sb.push_back(64'hFACE_FACE_FACE_FACE);
    write_word(64'hFACE_FACE_FACE_FACE);
    write_word(64'h0BAD_0BAD_0BAD_0BAD);
    repeat (39) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {60'd0, clkPin_o, dataPin_o, busy_o, empty_o}, 64'd1);
    sb.delete();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    sb.push_back(64'h8000_0000_0000_0001);
    write_word(64'h8000_0000_0000_0001);
    drain();

    // enable dropped during GAP with two words queued
    sb.push_back(64'h1234_5678_9ABC_DEF0);
    write_word(64'h1234_5678_9ABC_DEF0);
    sb.push_back(64'h5555_AAAA_5555_AAAA);
    write_word(64'h5555_AAAA_5555_AAAA);
    sb.push_back(64'h0000_0000_0000_00FF);
    write_word(64'h0000_0000_0000_00FF);
    repeat (140) @(negedge clk);
    enable_i = 1'b0;
    wait_msg(at, ok);
    check("gap_drop_msg_seen", {63'd0, ok}, 64'd1);
    repeat (400) @(negedge clk);
    check("gap_drop_idle", {61'd0, busy_o, clkPin_o, empty_o}, 64'd0);
    check("gap_drop_queued", 64'(sb.size()), 64'd2);
    enable_i = 1'b1;
    drain();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
